// File: rtl/udp_oe_pkg.sv
// Shared types and IPv4 header constants for the UDP offload engine
// configuration path.
package udp_oe_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ASSERT  = 3'd1,
    S_DRAIN   = 3'd2,
    S_LOAD    = 3'd3,
    S_CSUM    = 3'd4,
    S_RELEASE = 3'd5
  } t_cfg_seq_state;

  typedef struct packed {
    logic [47:0] fpga_mac_adr;
    logic [31:0] fpga_ip_adr;
    logic [15:0] fpga_udp_port;
    logic [31:0] fpga_netmask;
    logic [47:0] host_mac_adr;
    logic [31:0] host_ip_adr;
    logic [15:0] host_udp_port;
    logic [15:0] payload_per_packet;
  } t_udp_oe_cfg;

  // Fixed IPv4 header words: version/IHL/TOS, identification, flags (DF)
  localparam logic [15:0] IP_VER_IHL_TOS = 16'h4500;
  localparam logic [15:0] IP_ID          = 16'h0000;
  localparam logic [15:0] IP_FLAGS_DF    = 16'h4000;

endpackage

// File: rtl/udp_oe_csum16_acc.sv
// 16-bit one's-complement accumulator with end-around carry.
// sum shows the accumulator including the word presented this cycle,
// so a caller can capture the final result on the last word.
module udp_oe_csum16_acc (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        valid,
  input  logic [15:0] word,
  output logic [15:0] sum
);

  logic [15:0] acc;
  logic [16:0] raw;

  // 17-bit add, carry folded back in (cannot carry a second time)
  always_comb begin
    raw = {1'b0, acc} + {1'b0, (valid ? word : 16'h0000)};
    sum = raw[15:0] + {15'b0, raw[16]};
  end

  // Accumulator register
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc <= 16'h0000;
    end else if (valid) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/udp_oe_cfg_sequencer.sv
// Configuration sequencer: holds the TX/RX paths in reset, waits for them
// to drain, loads the shadow configuration atomically, precomputes the
// partial IPv4 header checksum and then releases the paths.
module udp_oe_cfg_sequencer
  import udp_oe_pkg::*;
#(
  parameter int          RST_HOLD_CYCLES = 16,
  parameter int          DRAIN_TIMEOUT   = 1024,
  parameter logic [7:0]  IP_TTL          = 8'h40,
  parameter logic [7:0]  IP_PROTO        = 8'h11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_wr_valid,
  output logic        cfg_ready,
  input  logic        sw_rst_req,
  input  logic [47:0] stg_fpga_mac_adr,
  input  logic [31:0] stg_fpga_ip_adr,
  input  logic [15:0] stg_fpga_udp_port,
  input  logic [31:0] stg_fpga_netmask,
  input  logic [47:0] stg_host_mac_adr,
  input  logic [31:0] stg_host_ip_adr,
  input  logic [15:0] stg_host_udp_port,
  input  logic [15:0] stg_payload_per_packet,
  input  logic [15:0] tx_sm_state,
  input  logic [15:0] rx_sm_state,
  output logic [47:0] fpga_mac_adr,
  output logic [31:0] fpga_ip_adr,
  output logic [15:0] fpga_udp_port,
  output logic [31:0] fpga_netmask,
  output logic [47:0] host_mac_adr,
  output logic [31:0] host_ip_adr,
  output logic [15:0] host_udp_port,
  output logic [15:0] payload_per_packet,
  output logic [15:0] checksum_ip,
  output logic        tx_rst,
  output logic        rx_rst,
  output logic        cfg_done,
  output logic        drain_timeout,
  output logic [2:0]  seq_state
);

  localparam int CNT_W = $clog2(DRAIN_TIMEOUT + RST_HOLD_CYCLES + 1);

  t_cfg_seq_state state, state_next;
  t_udp_oe_cfg    stg, shadow, live;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic [2:0]  csum_idx;
  logic [15:0] csum_word, csum_sum;
  logic        rst_hold;
  logic        accept, cnt_clear, cnt_en, set_timeout, load_en;
  logic        acc_clear, csum_valid, csum_last, hold_met, timeout_hit, paths_idle;

  assign stg = {stg_fpga_mac_adr, stg_fpga_ip_adr, stg_fpga_udp_port, stg_fpga_netmask,
                stg_host_mac_adr, stg_host_ip_adr, stg_host_udp_port, stg_payload_per_packet};

  assign cnt_inc     = cnt + 1'b1;
  assign hold_met    = (cnt_inc >= CNT_W'(RST_HOLD_CYCLES));
  assign timeout_hit = (cnt_inc >= CNT_W'(DRAIN_TIMEOUT));
  assign paths_idle  = (tx_sm_state == 16'h0000) && (rx_sm_state == 16'h0000);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and per-state control strobes
  always_comb begin
    state_next  = state;
    cfg_ready   = 1'b0;
    accept      = 1'b0;
    cnt_clear   = 1'b0;
    cnt_en      = 1'b0;
    set_timeout = 1'b0;
    load_en     = 1'b0;
    acc_clear   = 1'b0;
    csum_valid  = 1'b0;
    csum_last   = 1'b0;
    cfg_done    = 1'b0;
    case (state)
      S_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_wr_valid || sw_rst_req) begin
          accept     = 1'b1;
          state_next = S_ASSERT;
        end
      end
      S_ASSERT: begin
        cnt_clear  = 1'b1;
        state_next = S_DRAIN;
      end
      S_DRAIN: begin
        cnt_en = 1'b1;
        if (hold_met && paths_idle) begin
          state_next = S_LOAD;
        end else if (timeout_hit) begin
          set_timeout = 1'b1;
          state_next  = S_LOAD;
        end
      end
      S_LOAD: begin
        load_en    = 1'b1;
        acc_clear  = 1'b1;
        state_next = S_CSUM;
      end
      S_CSUM: begin
        csum_valid = 1'b1;
        if (csum_idx == 3'd7) begin
          csum_last  = 1'b1;
          state_next = S_RELEASE;
        end
      end
      S_RELEASE: begin
        cfg_done   = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Header word presented to the accumulator on each checksum cycle
  always_comb begin
    csum_word = 16'h0000;
    case (csum_idx)
      3'd0: csum_word = IP_VER_IHL_TOS;
      3'd1: csum_word = IP_ID;
      3'd2: csum_word = IP_FLAGS_DF;
      3'd3: csum_word = {IP_TTL, IP_PROTO};
      3'd4: csum_word = live.fpga_ip_adr[31:16];
      3'd5: csum_word = live.fpga_ip_adr[15:0];
      3'd6: csum_word = live.host_ip_adr[31:16];
      3'd7: csum_word = live.host_ip_adr[15:0];
      default: csum_word = 16'h0000;
    endcase
  end

  udp_oe_csum16_acc u_csum (
    .clk   (clk),
    .reset (reset),
    .clear (acc_clear),
    .valid (csum_valid),
    .word  (csum_word),
    .sum   (csum_sum)
  );

  // Shadow capture on accept, atomic load of live config, checksum result
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow      <= '0;
      live        <= '0;
      checksum_ip <= 16'h0000;
    end else begin
      if (accept && cfg_wr_valid) shadow <= stg;
      if (load_en) live <= shadow;
      if (csum_last) checksum_ip <= csum_sum;
    end
  end

  // Drain counter, checksum word index, path reset and timeout flag
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt           <= '0;
      csum_idx      <= 3'd0;
      rst_hold      <= 1'b1;
      drain_timeout <= 1'b0;
    end else begin
      if (cnt_clear) cnt <= '0;
      else if (cnt_en) cnt <= cnt_inc;
      if (load_en) csum_idx <= 3'd0;
      else if (csum_valid) csum_idx <= csum_idx + 3'd1;
      if (accept) begin
        rst_hold      <= 1'b1;
        drain_timeout <= 1'b0;
      end
      if (set_timeout) drain_timeout <= 1'b1;
      if (csum_last) rst_hold <= 1'b0;
    end
  end

  assign tx_rst    = rst_hold;
  assign rx_rst    = rst_hold;
  assign seq_state = state;

  assign fpga_mac_adr       = live.fpga_mac_adr;
  assign fpga_ip_adr        = live.fpga_ip_adr;
  assign fpga_udp_port      = live.fpga_udp_port;
  assign fpga_netmask       = live.fpga_netmask;
  assign host_mac_adr       = live.host_mac_adr;
  assign host_ip_adr        = live.host_ip_adr;
  assign host_udp_port      = live.host_udp_port;
  assign payload_per_packet = live.payload_per_packet;

endmodule

// File: tb/tb_udp_oe_cfg_sequencer.sv
// Directed bench for udp_oe_cfg_sequencer with hand-computed checksums.
module tb_udp_oe_cfg_sequencer;

  logic        clk, reset;
  logic        cfg_wr_valid, cfg_ready, sw_rst_req;
  logic [47:0] stg_fpga_mac_adr, stg_host_mac_adr;
  logic [31:0] stg_fpga_ip_adr, stg_fpga_netmask, stg_host_ip_adr;
  logic [15:0] stg_fpga_udp_port, stg_host_udp_port, stg_payload_per_packet;
  logic [15:0] tx_sm_state, rx_sm_state;
  logic [47:0] fpga_mac_adr, host_mac_adr;
  logic [31:0] fpga_ip_adr, fpga_netmask, host_ip_adr;
  logic [15:0] fpga_udp_port, host_udp_port, payload_per_packet, checksum_ip;
  logic        tx_rst, rx_rst, cfg_done, drain_timeout;
  logic [2:0]  seq_state;

  int checks = 0;
  int failures = 0;
  int n;
  int rst_bad;

  udp_oe_cfg_sequencer dut (
    .clk(clk), .reset(reset),
    .cfg_wr_valid(cfg_wr_valid), .cfg_ready(cfg_ready), .sw_rst_req(sw_rst_req),
    .stg_fpga_mac_adr(stg_fpga_mac_adr), .stg_fpga_ip_adr(stg_fpga_ip_adr),
    .stg_fpga_udp_port(stg_fpga_udp_port), .stg_fpga_netmask(stg_fpga_netmask),
    .stg_host_mac_adr(stg_host_mac_adr), .stg_host_ip_adr(stg_host_ip_adr),
    .stg_host_udp_port(stg_host_udp_port), .stg_payload_per_packet(stg_payload_per_packet),
    .tx_sm_state(tx_sm_state), .rx_sm_state(rx_sm_state),
    .fpga_mac_adr(fpga_mac_adr), .fpga_ip_adr(fpga_ip_adr), .fpga_udp_port(fpga_udp_port),
    .fpga_netmask(fpga_netmask), .host_mac_adr(host_mac_adr), .host_ip_adr(host_ip_adr),
    .host_udp_port(host_udp_port), .payload_per_packet(payload_per_packet),
    .checksum_ip(checksum_ip), .tx_rst(tx_rst), .rx_rst(rx_rst), .cfg_done(cfg_done),
    .drain_timeout(drain_timeout), .seq_state(seq_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_stg(input logic [31:0] fip, input logic [31:0] hip);
    stg_fpga_ip_adr        = fip;
    stg_host_ip_adr        = hip;
    stg_fpga_mac_adr       = {16'h0200, fip};
    stg_host_mac_adr       = {16'h0400, hip};
    stg_fpga_udp_port      = fip[15:0] ^ 16'h1000;
    stg_host_udp_port      = hip[15:0] ^ 16'h2000;
    stg_fpga_netmask       = 32'hFFFFFF00;
    stg_payload_per_packet = 16'd1024;
  endtask

  // Present a command for one edge (DUT assumed idle); n = 1 afterwards
  task automatic cmd(input logic wr, input logic sw);
    cfg_wr_valid = wr;
    sw_rst_req   = sw;
    step();
    cfg_wr_valid = 1'b0;
    sw_rst_req   = 1'b0;
    n = 1;
    rst_bad = 0;
  endtask

  // Advance until cfg_done, counting cycles and any early reset release
  task automatic wait_done();
    int budget;
    budget = 0;
    while (!cfg_done && budget < 3000) begin
      if (!(tx_rst && rx_rst)) rst_bad++;
      step();
      n++;
      budget++;
    end
    check("done_seen", cfg_done, 1'b1);
  endtask

  task automatic wait_state(input logic [2:0] s);
    int budget;
    budget = 0;
    while (seq_state != s && budget < 3000) begin
      step();
      n++;
      budget++;
    end
    check("state_reached", seq_state, s);
  endtask

  initial begin
    int bad;
    reset = 1'b1;
    cfg_wr_valid = 1'b0;
    sw_rst_req = 1'b0;
    tx_sm_state = 16'h0;
    rx_sm_state = 16'h0;
    set_stg(32'h0, 32'h0);
    repeat (3) step();
    reset = 1'b0;
    step();

    // Reset state, then 100 quiet cycles
    check("rst_tx_rst", tx_rst, 1'b1);
    check("rst_rx_rst", rx_rst, 1'b1);
    check("rst_cfg_ready", cfg_ready, 1'b1);
    check("rst_state", seq_state, 3'd0);
    check("rst_cfg_done", cfg_done, 1'b0);
    check("rst_timeout", drain_timeout, 1'b0);
    check("rst_fpga_mac", fpga_mac_adr, 48'h0);
    check("rst_csum", checksum_ip, 16'h0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (!tx_rst || !rx_rst || !cfg_ready || fpga_ip_adr != 0 || host_ip_adr != 0 ||
          payload_per_packet != 0 || checksum_ip != 0 || seq_state != 0) bad++;
      step();
    end
    check("idle_100_cycles", bad, 0);

    // Basic commit: latency 27, checksum 466E
    set_stg(32'hC0A8000A, 32'hC0A80001);
    cmd(1'b1, 1'b0);
    check("assert_state", seq_state, 3'd1);
    wait_done();
    check("latency_basic", n, 27);
    check("rst_held_until_release", rst_bad, 0);
    check("release_tx_rst", tx_rst, 1'b0);
    check("release_rx_rst", rx_rst, 1'b0);
    check("csum_basic", checksum_ip, 16'h466E);
    check("fpga_ip", fpga_ip_adr, 32'hC0A8000A);
    check("host_ip", host_ip_adr, 32'hC0A80001);
    check("fpga_mac", fpga_mac_adr, 48'h0200C0A8000A);
    check("host_mac", host_mac_adr, 48'h0400C0A80001);
    check("fpga_port", fpga_udp_port, 16'h100A);
    check("host_port", host_udp_port, 16'h2001);
    check("netmask", fpga_netmask, 32'hFFFFFF00);
    check("payload", payload_per_packet, 16'd1024);
    step();
    check("done_one_cycle", cfg_done, 1'b0);
    check("back_idle", seq_state, 3'd0);
    check("idle_ready", cfg_ready, 1'b1);
    check("tx_rst_low_idle", tx_rst, 1'b0);

    // All-ones addresses: adding FFFF is neutral in one's complement, so
    // the sum stays at the constant-word total 4500+4000+4011 = C511
    set_stg(32'hFFFFFFFF, 32'hFFFFFFFF);
    cmd(1'b1, 1'b0);
    wait_done();
    check("latency_ones", n, 27);
    check("csum_ones", checksum_ip, 16'hC511);
    step();

    // TX busy for 200 cycles: nothing loads, no timeout
    tx_sm_state = 16'd3;
    set_stg(32'h0A000001, 32'h0A000002);
    cmd(1'b1, 1'b0);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      n++;
      if (!tx_rst || !rx_rst || fpga_ip_adr != 32'hFFFFFFFF || seq_state != 3'd2) bad++;
    end
    check("stall_hold", bad, 0);
    tx_sm_state = 16'd0;
    n = 0;
    wait_done();
    check("stall_release_latency", n, 10);
    check("stall_fpga_ip", fpga_ip_adr, 32'h0A000001);
    check("stall_csum", checksum_ip, 16'hD914);
    check("stall_no_timeout", drain_timeout, 1'b0);
    step();

    // TX stuck: LOAD after exactly 1024 DRAIN cycles, sticky timeout flag
    tx_sm_state = 16'd5;
    cmd(1'b1, 1'b0);
    wait_state(3'd3);
    check("timeout_load_cycle", n, 1026);
    check("timeout_flag_set", drain_timeout, 1'b1);
    wait_done();
    step();
    check("timeout_flag_sticky", drain_timeout, 1'b1);
    tx_sm_state = 16'd0;
    cmd(1'b0, 1'b1);
    check("timeout_cleared_on_accept", drain_timeout, 1'b0);
    wait_done();
    check("sw_rst_latency", n, 27);
    step();

    // Both requests together: one sequence with the new values
    set_stg(32'h01020304, 32'h05060708);
    cmd(1'b1, 1'b1);
    wait_done();
    check("both_fpga_ip", fpga_ip_adr, 32'h01020304);
    check("both_csum", checksum_ip, 16'hD525);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (seq_state != 3'd0) bad++;
    end
    check("both_single_sequence", bad, 0);

    // sw_rst_req alone: staged values ignored
    set_stg(32'h11111111, 32'h22222222);
    cmd(1'b0, 1'b1);
    wait_done();
    check("sw_only_fpga_ip", fpga_ip_adr, 32'h01020304);
    check("sw_only_csum", checksum_ip, 16'hD525);
    step();

    // Commit during CSUM is held off until IDLE
    set_stg(32'hC0A8000A, 32'hC0A80001);
    cmd(1'b1, 1'b0);
    wait_state(3'd4);
    set_stg(32'hFFFFFFFF, 32'hFFFFFFFF);
    cfg_wr_valid = 1'b1;
    check("busy_not_ready", cfg_ready, 1'b0);
    wait_done();
    check("busy_old_ip", fpga_ip_adr, 32'hC0A8000A);
    check("busy_old_csum", checksum_ip, 16'h466E);
    step();
    check("pending_idle", seq_state, 3'd0);
    check("pending_ready", cfg_ready, 1'b1);
    step();
    check("pending_accepted", seq_state, 3'd1);
    cfg_wr_valid = 1'b0;
    n = 1;
    wait_done();
    check("pending_new_ip", fpga_ip_adr, 32'hFFFFFFFF);
    check("pending_csum", checksum_ip, 16'hC511);
    step();

    // Reset during DRAIN: back to reset values, shadow discarded
    set_stg(32'h0A0B0C0D, 32'h01010101);
    cmd(1'b1, 1'b0);
    repeat (5) step();
    check("in_drain", seq_state, 3'd2);
    reset = 1'b1;
    step();
    check("abort_state", seq_state, 3'd0);
    check("abort_tx_rst", tx_rst, 1'b1);
    check("abort_fpga_ip", fpga_ip_adr, 32'h0);
    check("abort_csum", checksum_ip, 16'h0);
    check("abort_ready", cfg_ready, 1'b1);
    reset = 1'b0;
    step();
    cmd(1'b0, 1'b1);
    wait_done();
    check("shadow_cleared_mac", fpga_mac_adr, 48'h0);
    check("shadow_cleared_csum", checksum_ip, 16'hC511);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
